operand_mux_seq: RTL and testbench
==================================

// Module: operand_mux_seq
// PURPOSE
//  Parametrised operand selector/sequencer feeding the RSA Montgomery datapath.
//  Selects one of NUM_SRC operand buses or a constant (one, zero) and captures it.
//  Presents the operand in parallel, or streams it LSB-first under a valid/ready handshake.
//  Sits between the exponentiation controller and the bit-serial Montgomery multiplier.
// PARAMETERS
//  WIDTH    8   operand width in bits; legal range WIDTH >= 2
//  NUM_SRC  2   number of operand source buses; legal range NUM_SRC >= 1
//  SEL_W    $clog2(NUM_SRC+2)   select width (derived, not overridden)
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              synchronous, active-high reset
//  src_i      in   NUM_SRC*WIDTH  packed sources; src k = src_i[k*WIDTH +: WIDTH]
//  sel        in   SEL_W          source select, sampled with start
//  mode       in   1              0 = parallel only, 1 = parallel + serial stream; sampled with start
//  start      in   1              capture request; honoured only when ready=1
//  abort      in   1              terminate serial stream
//  ready      out  1              1 = idle, start accepted
//  dout       out  WIDTH          captured operand; holds until next accepted start
//  dout_valid out  1              1-cycle pulse, cycle after accepted start
//  ser_bit    out  1              current serial bit (LSB first)
//  ser_valid  out  1              ser_bit valid
//  ser_ready  in   1              consumer accepts ser_bit this cycle
//  ser_last   out  1              ser_valid and final bit (bit WIDTH-1)
// BEHAVIOUR
//  - Clock: single clock clk. Reset: rst is synchronous and active-high.
//  - Reset: state=IDLE, dout=0, dout_valid=0, ser_valid=0, ser_bit=0, ser_last=0, bit count=0, ready=1.
//  - Source decode: sel<NUM_SRC -> src[sel]; sel==NUM_SRC -> {0..0,1};
//    sel==NUM_SRC+1 -> all zero; any larger sel -> all zero.
//  - FSM states: IDLE, SHIFT. ready = (state==IDLE).
//  - IDLE, start=1, abort=0, cycle T: operand captured into dout and shift register.
//    T+1: dout_valid=1 for exactly one cycle.
//    mode=0: state stays IDLE.
//    mode=1: state=SHIFT, ser_valid=1, ser_bit=operand[0], count=0.
//  - SHIFT: on ser_valid & ser_ready: shift right and count++.
//    ser_ready=0: ser_bit, count and ser_last hold (no bit lost or repeated).
//  - Final bit: ser_last=1 while count==WIDTH-1. Handshake on that bit -> IDLE next cycle,
//    ser_valid=0, ready=1.
//  - Stream length: exactly WIDTH handshakes. Counter width $clog2(WIDTH), no wrap past WIDTH-1.
//  - Source stability: src_i/sel/mode changes after capture do not affect dout or the stream.
//  - start while in SHIFT: ignored. No queueing.
//  - abort in SHIFT: next cycle IDLE, ser_valid=0, ser_last=0; dout retained.
//    abort in IDLE: no effect. abort with start in IDLE: abort wins, start dropped.
//  - abort and final-bit handshake in same cycle: -> IDLE (identical result).
//  - rst mid-stream: reset values next cycle; dout cleared to 0.
//  - Back-to-back parallel captures are legal every cycle (mode=0); dout_valid may stay high
//    continuously.
// TESTING (WIDTH=8, NUM_SRC=2 unless noted)
//  1. src0=0xA5, src1=0x3C, sel=1, mode=0, start 1 cycle -> next cycle dout=0x3C,
//     dout_valid=1 for 1 cycle, ready=1 throughout.
//  2. sel=2 -> dout=0x01; sel=3 -> dout=0x00; NUM_SRC=3 build, sel=3 -> 0x01, sel=4 -> 0x00.
//  3. sel=0, mode=1, ser_ready=1 -> ser_bit 1,0,1,0,0,1,0,1 on 8 consecutive cycles.
//     ser_last only on 8th bit; ready=1 on the cycle after.
//  4. As 3, ser_ready=0 for 3 cycles after bit 2 -> ser_bit/ser_last hold.
//     Stream takes 11 cycles, same bit sequence, src_i changed during stream has no effect.
//  5. start while in SHIFT -> ignored. abort after 3 bits -> ser_valid=0 next cycle, ready=1,
//     dout still 0xA5.
//  6. rst asserted mid-stream -> next cycle all outputs at reset values.
//     Start+abort together in IDLE -> no capture, no dout_valid.

Source files
------------

// File: rtl/operand_mux_seq_if.sv
// Operand selector bus: controller-side sources/handshake and the
// operand/serial-stream outputs of operand_mux_seq.
//   master: drives src_i, sel, mode, start, abort, ser_ready
//   slave : drives ready, dout, dout_valid, ser_bit, ser_valid, ser_last
interface operand_mux_seq_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = $clog2(NUM_SRC + 2)
);
    logic [NUM_SRC*WIDTH-1:0] src_i;
    logic [SEL_W-1:0]         sel;
    logic                     mode;
    logic                     start;
    logic                     abort;
    logic                     ready;
    logic [WIDTH-1:0]         dout;
    logic                     dout_valid;
    logic                     ser_bit;
    logic                     ser_valid;
    logic                     ser_ready;
    logic                     ser_last;

    modport master (
        output src_i, sel, mode, start, abort, ser_ready,
        input  ready, dout, dout_valid, ser_bit, ser_valid, ser_last
    );

    modport slave (
        input  src_i, sel, mode, start, abort, ser_ready,
        output ready, dout, dout_valid, ser_bit, ser_valid, ser_last
    );
endinterface

// File: rtl/operand_mux_seq.sv
// Operand selector/sequencer for the Montgomery datapath: selects a source
// bus or constant, captures it, presents it in parallel and optionally
// streams it LSB-first over a valid/ready handshake.
// Ports: clk, rst (sync, active-high), bus (operand_mux_seq_if.slave).
module operand_mux_seq #(
    parameter int WIDTH   = 8,
    parameter int NUM_SRC = 2
) (
    input  logic              clk,
    input  logic              rst,
    operand_mux_seq_if.slave  bus
);
    localparam int SEL_W = $clog2(NUM_SRC + 2);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] r_sh;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dout_valid;
    logic [WIDTH-1:0] w_operand;
    logic             w_capture;
    logic             w_shift;
    logic             w_last;

    // Source decode: sources first, then constant one, everything
    // above that reads as zero.
    always_comb begin
        w_operand = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (bus.sel == SEL_W'(k)) begin
                w_operand = bus.src_i[k*WIDTH +: WIDTH];
            end
        end
        if (bus.sel == SEL_W'(NUM_SRC)) begin
            w_operand = WIDTH'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_shift     = 1'b0;
        w_last      = (r_state == S_SHIFT) &&
                      (r_cnt == CNT_W'(WIDTH - 1));
        unique case (r_state)
            S_IDLE: begin
                // abort takes priority and drops a coincident start
                if (bus.start && !bus.abort) begin
                    w_capture = 1'b1;
                    if (bus.mode) begin
                        w_state_nxt = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.ser_ready) begin
                    w_shift = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_dout       <= '0;
            r_sh         <= '0;
            r_cnt        <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_dout_valid <= w_capture;
            if (w_capture) begin
                r_dout <= w_operand;
                r_sh   <= w_operand;
                r_cnt  <= '0;
            end else if (w_shift) begin
                r_sh <= r_sh >> 1;
                // counter parks at zero after the final bit
                r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.ready      = (r_state == S_IDLE);
    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.ser_valid  = (r_state == S_SHIFT);
    assign bus.ser_bit    = (r_state == S_SHIFT) & r_sh[0];
    assign bus.ser_last   = w_last;
endmodule

// File: tb/tb_operand_mux_seq.sv
// Scoreboard bench for operand_mux_seq: directed stimulus pushes expected
// parallel/serial responses; a negedge monitor pops and compares.
module tb_operand_mux_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    operand_mux_seq_if #(.WIDTH(8), .NUM_SRC(2)) b ();
    operand_mux_seq_if #(.WIDTH(8), .NUM_SRC(3)) b3 ();

    operand_mux_seq #(.WIDTH(8), .NUM_SRC(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    operand_mux_seq #(.WIDTH(8), .NUM_SRC(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (b3.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] q_par[$];
    logic [1:0] q_ser[$];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_ser(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            q_ser.push_back({(i == 7), v[i]});
        end
    endtask

    // Monitor: every dout_valid pops a parallel entry; every presented
    // serial bit is compared to the queue head, popped on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (b.dout_valid) begin
                if (q_par.size() == 0) begin
                    check("unexpected dout_valid", 1, 0);
                end else begin
                    check("dout", {24'd0, b.dout}, {24'd0, q_par.pop_front()});
                end
            end
            if (b.ser_valid) begin
                if (q_ser.size() == 0) begin
                    check("unexpected ser_valid", 1, 0);
                end else begin
                    check("ser_bit", {31'd0, b.ser_bit}, {31'd0, q_ser[0][0]});
                    check("ser_last", {31'd0, b.ser_last}, {31'd0, q_ser[0][1]});
                    if (b.ser_ready) begin
                        void'(q_ser.pop_front());
                    end
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, " ready"}, {31'd0, b.ready}, 1);
        check({tag, " dout"}, {24'd0, b.dout}, 0);
        check({tag, " dout_valid"}, {31'd0, b.dout_valid}, 0);
        check({tag, " ser_valid"}, {31'd0, b.ser_valid}, 0);
        check({tag, " ser_bit"}, {31'd0, b.ser_bit}, 0);
        check({tag, " ser_last"}, {31'd0, b.ser_last}, 0);
    endtask

    initial begin
        int n;
        logic [7:0] v3 [4];
        logic [2:0] s3 [4];

        b.src_i = '0; b.sel = '0; b.mode = 0;
        b.start = 0; b.abort = 0; b.ser_ready = 0;
        b3.src_i = '0; b3.sel = '0; b3.mode = 0;
        b3.start = 0; b3.abort = 0; b3.ser_ready = 0;
        rst = 1;
        tick;
        tick;
        check_reset_vals("reset");
        rst = 0;
        tick;

        // parallel capture of src1
        b.src_i = {8'h3C, 8'hA5};
        b.sel = 1; b.mode = 0; b.start = 1;
        q_par.push_back(8'h3C);
        check("ready idle", {31'd0, b.ready}, 1);
        tick;
        b.start = 0;
        check("ready after cap", {31'd0, b.ready}, 1);
        check("dout_valid pulse", {31'd0, b.dout_valid}, 1);
        tick;
        check("dout_valid single", {31'd0, b.dout_valid}, 0);
        check("dout hold", {24'd0, b.dout}, 32'h3C);

        // constants, back-to-back captures
        b.sel = 2; b.start = 1;
        q_par.push_back(8'h01);
        tick;
        b.sel = 3;
        q_par.push_back(8'h00);
        tick;
        b.start = 0;
        tick;

        // full serial stream of 0xA5
        b.sel = 0; b.mode = 1; b.ser_ready = 1; b.start = 1;
        q_par.push_back(8'hA5);
        push_ser(8'hA5, 8);
        tick;
        b.start = 0;
        n = 0;
        while (!b.ready && n < 50) begin
            tick;
            n++;
        end
        check("stream cycles", n, 8);
        check("ser_valid after", {31'd0, b.ser_valid}, 0);
        tick;

        // stream with 3-cycle stall after bit 2, src change mid-stream
        b.start = 1;
        q_par.push_back(8'hA5);
        push_ser(8'hA5, 8);
        tick;
        b.start = 0;
        n = 0;
        tick; n++;
        tick; n++;
        b.ser_ready = 0;
        b.src_i = {8'hFF, 8'h5A};
        for (int i = 0; i < 3; i++) begin
            tick;
            n++;
        end
        b.ser_ready = 1;
        while (!b.ready && n < 50) begin
            tick;
            n++;
        end
        check("stalled stream cycles", n, 11);
        check("dout stable", {24'd0, b.dout}, 32'hA5);
        b.src_i = {8'h3C, 8'hA5};
        tick;

        // start ignored in SHIFT, abort after 3 bits
        b.sel = 0; b.mode = 1; b.start = 1;
        q_par.push_back(8'hA5);
        push_ser(8'hA5, 4);
        tick;
        b.sel = 1; b.mode = 0;
        tick;
        b.start = 0;
        tick;
        tick;
        b.ser_ready = 0;
        b.abort = 1;
        tick;
        b.abort = 0;
        b.ser_ready = 1;
        if (q_ser.size() > 0) void'(q_ser.pop_front());
        check("abort ser_valid", {31'd0, b.ser_valid}, 0);
        check("abort ser_last", {31'd0, b.ser_last}, 0);
        check("abort ready", {31'd0, b.ready}, 1);
        check("abort dout", {24'd0, b.dout}, 32'hA5);
        tick;

        // reset mid-stream
        b.sel = 0; b.mode = 1; b.start = 1;
        q_par.push_back(8'hA5);
        push_ser(8'hA5, 3);
        tick;
        b.start = 0;
        tick;
        tick;
        b.ser_ready = 0;
        rst = 1;
        tick;
        check_reset_vals("midrst");
        q_ser.delete();
        rst = 0;
        b.ser_ready = 1;
        tick;

        // start with abort in IDLE: dropped
        b.sel = 1; b.mode = 0; b.start = 1; b.abort = 1;
        tick;
        b.start = 0; b.abort = 0;
        check("start+abort dout_valid", {31'd0, b.dout_valid}, 0);
        check("start+abort dout", {24'd0, b.dout}, 0);
        tick;

        // NUM_SRC=3 decode
        b3.src_i = {8'h77, 8'h66, 8'h55};
        s3[0] = 3'd2; v3[0] = 8'h77;
        s3[1] = 3'd3; v3[1] = 8'h01;
        s3[2] = 3'd4; v3[2] = 8'h00;
        s3[3] = 3'd5; v3[3] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            b3.sel = s3[i];
            b3.start = 1;
            tick;
            check($sformatf("n3 sel%0d valid", s3[i]),
                  {31'd0, b3.dout_valid}, 1);
            check($sformatf("n3 sel%0d dout", s3[i]),
                  {24'd0, b3.dout}, {24'd0, v3[i]});
        end
        b3.start = 0;
        tick;
        tick;

        check("par queue drained", q_par.size(), 0);
        check("ser queue drained", q_ser.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
